mips_multicycle_control: RTL

//  Multi-cycle MIPS main control FSM, directly upstream of ALUControl.

---
 rtl/mips_multicycle_control.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: sequences each instruction from FETCH through
// writeback and drives datapath enables plus the ALU_op/funct_sel pair for ALUControl.
module mips_multicycle_control #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] ALU_op,
  output logic       funct_sel,
  output logic       illegal
);

  // state  | meaning
  // FETCH  | read instruction, PC <- PC + 4
  // DECODE | branch target into ALUOut, dispatch on opcode
  // MEMADR | effective address for LW/SW
  // MEMRD  | data memory read
  // MEMWB  | MDR into register file
  // MEMWR  | data memory write
  // RTEX   | R-type ALU operation
  // ALUWB  | R-type result into rd
  // BEQ    | compare, conditional PC load from ALUOut
  // IMMEX  | immediate ALU operation
  // IMMWB  | immediate result into rt
  // JUMP   | PC <- jump target
  // HALT   | trapped on illegal opcode, waits for reset
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEX,
    S_ALUWB, S_BEQ, S_IMMEX, S_IMMWB, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  state_t state, state_nxt;
  logic   started;
  logic   pc_write, pc_write_cond;

  // started holds off the first FETCH until one clock after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    ALU_op        = 2'b00;
    funct_sel     = 1'b0;
    illegal       = 1'b0;
    if (started && !rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW:            state_nxt = S_MEMADR;
            OP_RTYPE:                state_nxt = S_RTEX;
            OP_BEQ:                  state_nxt = S_BEQ;
            OP_J:                    state_nxt = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI: state_nxt = S_IMMEX;
            default: begin
              illegal   = 1'b1;
              state_nxt = ILLEGAL_TRAP ? S_HALT : S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_read  = 1'b1;
          i_or_d    = 1'b1;
          state_nxt = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_RTEX: begin
          alu_src_a = 1'b1;
          ALU_op    = 2'b10;
          state_nxt = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BEQ: begin
          alu_src_a     = 1'b1;
          ALU_op        = 2'b01;
          pc_source     = 2'b01;
          pc_write_cond = 1'b1;
        end
        S_IMMEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          // ANDI/ORI let ALUControl decode the opcode; ADDI is a plain add
          if (opcode != OP_ADDI) begin
            ALU_op    = 2'b10;
            funct_sel = 1'b1;
          end
          state_nxt = S_IMMWB;
        end
        S_IMMWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_source = 2'b10;
          pc_write  = 1'b1;
        end
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  assign pc_en = pc_write | (pc_write_cond & zero);

endmodule
